switch_xbar: RTL
================

SWITCH_XBAR -- requirements
Module: switch_xbar

Interface
REQ-001 Parameter: DW, default 8, flit data width in bits.
REQ-002 Parameter: CW, default 16, width of the forwarded-flit counter.
REQ-003 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: direction  input  3  input-port grant from the switch arbiter: 0 Local, 1 North, 2 South, 3 East, 4 West; 5-7 illegal.
REQ-006 Port: in_valid  input  5  per-input-port flit valid; bit k corresponds to direction code k.
REQ-007 Port: in_data  input  5*DW  per-input-port flit; port k occupies bits [k*DW +: DW].
REQ-008 Port: in_ready  output  5  per-input-port accept, combinational.
REQ-009 Port: out_valid  output  1  output flit valid, registered.
REQ-010 Port: out_data  output  DW  output flit, registered.
REQ-011 Port: out_port  output  3  direction code of the input that supplied out_data, registered.
REQ-012 Port: out_ready  input  1  downstream accept.
REQ-013 Port: fwd_cnt  output  CW  count of completed output handshakes, registered.
REQ-014 Port: bad_dir  output  1  sticky flag, set on an illegal direction code.

Function
REQ-015 The block SHALL forward flits from the input port selected by direction into one output holding register.
REQ-016 The holding register SHALL have two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-017 free = !out_valid | out_ready.
REQ-018 in_ready[k] SHALL be 1 only when direction==k, k<=4, and free=1; all other bits SHALL be 0.
REQ-019 When direction>=5, in_ready SHALL be 00000 and no flit SHALL be accepted.
REQ-020 An accept occurs when in_valid[k] & in_ready[k] are both 1.
REQ-021 On an accept, on the next edge the block SHALL set out_valid=1, out_data=in_data[k], and out_port=k. Latency is one cycle.
REQ-022 In FULL with out_ready=0, out_valid, out_data, and out_port SHALL hold stable.
REQ-023 In FULL with out_ready=1 and no accept, the register SHALL go EMPTY on the next edge.
REQ-024 In FULL with out_ready=1 and a simultaneous accept, the register SHALL load the new flit and stay FULL. There is no bubble, and full throughput is one flit per cycle.
REQ-025 A change of direction while FULL SHALL NOT alter out_port or out_data of the held flit.
REQ-026 in_valid bits of non-selected ports SHALL be ignored, and their flits SHALL NOT be dropped or consumed.
REQ-027 fwd_cnt SHALL increment by 1 on every cycle with out_valid & out_ready, and SHALL wrap modulo 2^CW (all-ones -> 0).
REQ-028 bad_dir SHALL be set on the edge following any cycle with direction>=5, and SHALL remain 1 until reset.
REQ-029 out_valid SHALL NOT depend combinationally on out_ready. in_ready MAY depend combinationally on out_ready and direction.

Reset
REQ-030 While rst_n=0, out_valid=0, out_data=0, out_port=0, fwd_cnt=0, bad_dir=0, and in_ready=00000, independent of clk.
REQ-031 Reset asserted mid-transfer SHALL discard the held flit immediately. After rst_n deasserts, the first accept SHALL occur no earlier than the first posedge with rst_n=1.

Verification
REQ-032 Single flit: direction=2, in_valid=00100, in_data[2]=8'hA5, out_ready=1 -> next cycle out_valid=1, out_data=A5, out_port=2; fwd_cnt=1 one cycle later.
REQ-033 Backpressure: FULL with out_data=3C, out_ready=0 for 4 cycles while direction steps 0->1->2 -> out_data=3C and out_port unchanged, in_ready=00000 throughout, no flit lost.
REQ-034 Streaming: direction=4, in_valid[4]=1 for 10 cycles, out_ready=1 -> 10 back-to-back flits with out_valid continuously 1, fwd_cnt=10.
REQ-035 Illegal grant: direction=6 for 1 cycle with in_valid=11111 -> in_ready=00000, no accept, bad_dir=1 and stays 1 after direction returns to 0.
REQ-036 Counter wrap: CW=4, 16 handshakes -> fwd_cnt sequence 1..15, then 0.
REQ-037 Reset mid-operation: FULL, pull rst_n low between edges -> out_valid=0 and fwd_cnt=0 immediately. After release, a fresh accept on port 0 gives out_port=0 one cycle later.

Source files
------------

// File: rtl/switch_xbar.sv
// switch_xbar: one output port of a 5-input mesh router crossbar.
//
// The switch arbiter names one input port through `direction`; that port's
// flit is moved into a single output holding register, which then presents
// it downstream until it is taken.
//
// Handshake rule (every port): a transfer happens on a rising clk edge where
// valid and ready are both 1. A valid flit holds its data stable until that
// edge, and ready never waits on valid.
//
// Ports
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous, active-low reset
//   direction  in   3   granted input: 0 Local, 1 North, 2 South, 3 East,
//                       4 West; 5-7 are illegal
//   in_valid   in   5   per-input flit valid, bit k = direction code k
//   in_data    in   5*DW per-input flit, port k at [k*DW +: DW]
//   in_ready   out  5   per-input accept (combinational)
//   out_valid  out  1   output flit valid (registered)
//   out_data   out  DW  output flit (registered)
//   out_port   out  3   direction code the held flit came from (registered)
//   out_ready  in   1   downstream accept
//   fwd_cnt    out  CW  completed output handshakes, wraps modulo 2^CW
//   bad_dir    out  1   sticky: an illegal direction code was seen
module switch_xbar #(
  parameter int DW = 8,
  parameter int CW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        direction,
  input  logic [4:0]        in_valid,
  input  logic [5*DW-1:0]   in_data,
  output logic [4:0]        in_ready,
  output logic              out_valid,
  output logic [DW-1:0]     out_data,
  output logic [2:0]        out_port,
  input  logic              out_ready,
  output logic [CW-1:0]     fwd_cnt,
  output logic              bad_dir
);

  // Holding register state; out_valid is a direct decode of it.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   data_q, data_d;
  logic [2:0]      port_q, port_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            bad_q, bad_d;

  logic            dir_ok;
  logic            free;
  logic            accept;
  logic            out_fire;
  logic [DW-1:0]   sel_data;

  assign dir_ok   = (direction <= 3'd4);
  // The register can take a flit when it is empty or is being drained this
  // cycle, which gives one flit per cycle with no bubble.
  assign free     = (state_q == EMPTY) | out_ready;
  assign out_fire = (state_q == FULL) & out_ready;

  // rst_n gates in_ready so nothing is offered while reset is held, without
  // waiting for a clock edge.
  always_comb begin
    in_ready = 5'b00000;
    if (rst_n && free && dir_ok) begin
      in_ready = 5'b00001 << direction;
    end
  end

  assign accept = |(in_valid & in_ready);

  always_comb begin
    sel_data = '0;
    case (direction)
      3'd0:    sel_data = in_data[0*DW +: DW];
      3'd1:    sel_data = in_data[1*DW +: DW];
      3'd2:    sel_data = in_data[2*DW +: DW];
      3'd3:    sel_data = in_data[3*DW +: DW];
      3'd4:    sel_data = in_data[4*DW +: DW];
      default: sel_data = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      port_q  <= 3'd0;
      cnt_q   <= '0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      port_q  <= port_d;
      cnt_q   <= cnt_d;
      bad_q   <= bad_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    port_d  = port_q;
    cnt_d   = cnt_q;
    bad_d   = bad_q | ~dir_ok;
    case (state_q)
      EMPTY: begin
        if (accept) state_d = FULL;
      end
      FULL: begin
        if (accept)         state_d = FULL;
        else if (out_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
    // Data and port only move on an accept, so a direction change while the
    // register is held cannot disturb the flit already captured.
    if (accept) begin
      data_d = sel_data;
      port_d = direction;
    end
    if (out_fire) begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // Output logic
  always_comb begin
    out_valid = (state_q == FULL);
    out_data  = data_q;
    out_port  = port_q;
    fwd_cnt   = cnt_q;
    bad_dir   = bad_q;
  end

endmodule
